enc_sample_ctrl: RTL and testbench
==================================

ENC_SAMPLE_CTRL -- requirements
Module: enc_sample_ctrl

Interface
REQ-001 Parameter CH, default 4: number of wheel encoder channels.
REQ-002 Parameter CW, default 16: signed count width per channel.
REQ-003 Parameter PERIOD, default 50000: sample period in Clk cycles; 1 ms at 50 MHz.
REQ-004 Clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 Enable  input  1  1 = sampling runs; 0 = sampling halted.
REQ-007 CntPulse  input  CH  per-channel one-cycle count strobe from the quadrature decoder.
REQ-008 CntDir  input  CH  per-channel direction; 1 = increment, 0 = decrement; qualified by CntPulse.
REQ-009 SampleTick  output  1  one-cycle pulse at each period boundary.
REQ-010 DataOut  output  CW  signed snapshot count of the channel on ChanOut.
REQ-011 ChanOut  output  clog2(CH)  channel index of DataOut.
REQ-012 DataValid  output  1  DataOut/ChanOut valid.
REQ-013 DataReady  input  1  consumer accepts the word when high with DataValid.
REQ-014 Busy  output  1  frame transmission in progress.
REQ-015 Overrun  output  1  sticky: a snapshot was dropped.
REQ-016 ClrOverrun  input  1  clears Overrun.

Function
REQ-017 Period counter SHALL count 0..PERIOD-1 while Enable=1, then wrap to 0; terminal count SHALL assert SampleTick in the same cycle.
REQ-018 Per channel, each cycle with CntPulse[i]=1: acc[i] SHALL change by +1 (CntDir[i]=1) or -1 (CntDir[i]=0), two's complement, CW bits.
REQ-019 On SampleTick: snapshot value = acc[i] including that cycle's pulse; acc[i] SHALL load 0; no pulse is lost or double-counted.
REQ-020 FSM states IDLE and SEND; Busy=1 exactly in SEND.
REQ-021 IDLE + SampleTick: snap[] SHALL load snapshot values, idx=0, next state SEND; DataValid SHALL rise the following cycle.
REQ-022 In SEND: DataValid=1, ChanOut=idx, DataOut=snap[idx]; outputs SHALL hold stable until DataValid&DataReady.
REQ-023 On transfer with idx<CH-1: idx SHALL increment, DataValid stays 1; back-to-back one word per cycle when DataReady held high.
REQ-024 On transfer with idx=CH-1: SHALL return to IDLE, DataValid=0 next cycle.
REQ-025 SampleTick while in SEND: snap[] SHALL NOT change, acc[] SHALL still clear per REQ-019, Overrun SHALL set.
REQ-026 SampleTick coinciding with the last transfer (REQ-024) counts as in SEND: snapshot dropped, Overrun set.
REQ-027 ClrOverrun clears Overrun; simultaneous set condition SHALL win.
REQ-028 Enable=0: period counter and acc[] SHALL hold 0, no SampleTick; an in-flight frame SHALL complete normally.
REQ-029 Enable 0->1: first SampleTick SHALL occur PERIOD cycles after the first cycle with Enable=1.

Reset
REQ-030 reset=1 at a rising Clk edge SHALL force: period counter 0, acc[] 0, snap[] 0, idx 0, state IDLE.
REQ-031 Reset values of outputs: SampleTick 0, DataOut 0, ChanOut 0, DataValid 0, Busy 0, Overrun 0.
REQ-032 reset mid-frame SHALL abort the frame without completing outstanding words; reset overrides all other inputs.

Configuration
REQ-033 Macro ENC_SAT_EN defined: acc[] SHALL saturate at +2^(CW-1)-1 and -2^(CW-1); further pulses in the saturating direction SHALL be ignored.
REQ-034 Macro ENC_SAT_EN undefined: acc[] SHALL wrap modulo 2^CW.

Verification
REQ-035 PERIOD=100, ch0 10 pulses dir=1, ch1 3 pulses dir=0, DataReady=1 -> SampleTick at cycle 99; words (0,+10),(1,-3),(2,0),(3,0) on 4 consecutive cycles.
REQ-036 DataReady=0 for 5 cycles in the frame -> DataOut/ChanOut held constant, no word skipped or repeated.
REQ-037 DataReady=0 across two periods -> Overrun=1, first frame data intact; ClrOverrun -> Overrun=0.
REQ-038 Pulse on ch2 in the SampleTick cycle -> counted in the current snapshot; next period's ch2 count starts at 0.
REQ-039 CW=8, 130 pulses dir=1 on ch0 -> +127 with ENC_SAT_EN, -126 without.
REQ-040 reset asserted mid-frame at idx=2 -> next cycle DataValid=0, Busy=0, all outputs 0; next SampleTick PERIOD cycles after reset release.

Source files
------------

// File: rtl/enc_sample_ctrl.sv
// enc_sample_ctrl: per-channel wheel encoder accumulators, sampled every
// PERIOD cycles and streamed out one channel per word over a valid/ready port.
// Optional build macro ENC_SAT_EN: accumulators saturate instead of wrapping.

// One accumulator lane: exposes the value including this cycle's pulse so a
// snapshot taken on the tick cycle never loses or double-counts a pulse.
module enc_sample_lane #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  input  logic          pulse,
  input  logic          dir,
  output logic [CW-1:0] snap_val
);
  localparam logic [CW-1:0] ONE  = CW'(1);
`ifdef ENC_SAT_EN
  localparam logic [CW-1:0] MAXV = {1'b0, {(CW-1){1'b1}}};
  localparam logic [CW-1:0] MINV = {1'b1, {(CW-1){1'b0}}};
`endif

  logic [CW-1:0] acc_q, acc_d;

  // Next count: apply this cycle's pulse, then clear on tick or while halted
  always_comb begin
    snap_val = acc_q;
    if (pulse) begin
`ifdef ENC_SAT_EN
      if (dir && (acc_q != MAXV))       snap_val = acc_q + ONE;
      else if (!dir && (acc_q != MINV)) snap_val = acc_q - ONE;
`else
      snap_val = dir ? (acc_q + ONE) : (acc_q - ONE);
`endif
    end
    acc_d = (!en || clr) ? '0 : snap_val;
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end
endmodule

module enc_sample_ctrl #(
  parameter int CH     = 4,
  parameter int CW     = 16,
  parameter int PERIOD = 50000
) (
  input  logic                                   Clk,
  input  logic                                   reset,
  input  logic                                   Enable,
  input  logic [CH-1:0]                          CntPulse,
  input  logic [CH-1:0]                          CntDir,
  output logic                                   SampleTick,
  output logic [CW-1:0]                          DataOut,
  output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] ChanOut,
  output logic                                   DataValid,
  input  logic                                   DataReady,
  output logic                                   Busy,
  output logic                                   Overrun,
  input  logic                                   ClrOverrun
);
  localparam int            IW   = (CH > 1) ? $clog2(CH) : 1;
  localparam int            PW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] TERM = PW'(PERIOD - 1);
  localparam logic [IW-1:0] LAST = IW'(CH - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          cnt_q, cnt_d;
  logic [CH-1:0][CW-1:0]  snap_q, snap_d;
  logic [CH-1:0][CW-1:0]  snap_val;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   ovr_q, ovr_d;
  logic                   tick;

  // Tick is suppressed while reset is asserted so reset dominates every output
  assign tick = Enable && !reset && (cnt_q == TERM);

  // Period counter: held at 0 while disabled, wraps on terminal count
  always_comb begin
    cnt_d = cnt_q + PW'(1);
    if (!Enable || tick) cnt_d = '0;
  end

  for (genvar i = 0; i < CH; i++) begin : g_lane
    enc_sample_lane #(.CW(CW)) u_lane (
      .clk      (Clk),
      .reset    (reset),
      .en       (Enable),
      .clr      (tick),
      .pulse    (CntPulse[i]),
      .dir      (CntDir[i]),
      .snap_val (snap_val[i])
    );
  end

  // Frame FSM: capture on tick in IDLE, drain one word per accepted handshake
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: if (tick) begin
        snap_d  = snap_val;
        idx_d   = '0;
        state_d = SEND;
      end
      SEND: if (DataReady) begin
        if (idx_q == LAST) state_d = IDLE;
        else               idx_d   = idx_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase
    // A tick during SEND (including the last-word cycle) drops the snapshot;
    // the set beats a simultaneous clear.
    if (ClrOverrun)                 ovr_d = 1'b0;
    if (tick && (state_q == SEND))  ovr_d = 1'b1;
  end

  // State registers
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
      idx_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      ovr_q   <= ovr_d;
    end
  end

  assign SampleTick = tick;
  assign DataValid  = (state_q == SEND);
  assign Busy       = (state_q == SEND);
  assign Overrun    = ovr_q;
  // Word port reads zero outside a frame
  assign ChanOut    = DataValid ? idx_q : '0;
  assign DataOut    = DataValid ? snap_q[idx_q] : '0;
endmodule

// File: tb/tb_enc_sample_ctrl.sv
// Self-checking bench for enc_sample_ctrl: directed table for frame timing,
// hand sequences for overrun/reset/saturation, then random traffic vs a model.
module tb_enc_sample_ctrl;
  localparam int CH = 4, CW = 16, PERIOD = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, rdy, clr;
  logic [CH-1:0] pul, dir;
  logic          tick, valid, busy, ovr;
  logic [CW-1:0] dout;
  logic [1:0]    chan;

  // Second instance for the narrow-counter saturation/wrap case
  logic          en8, rdy8, clr8;
  logic [3:0]    pul8, dir8;
  logic          tick8, valid8, busy8, ovr8;
  logic [7:0]    data8;
  logic [1:0]    chan8;

  enc_sample_ctrl #(.CH(CH), .CW(CW), .PERIOD(PERIOD)) dut (
    .Clk(clk), .reset(rst), .Enable(en), .CntPulse(pul), .CntDir(dir),
    .SampleTick(tick), .DataOut(dout), .ChanOut(chan), .DataValid(valid),
    .DataReady(rdy), .Busy(busy), .Overrun(ovr), .ClrOverrun(clr));

  enc_sample_ctrl #(.CH(4), .CW(8), .PERIOD(200)) dut8 (
    .Clk(clk), .reset(rst), .Enable(en8), .CntPulse(pul8), .CntDir(dir8),
    .SampleTick(tick8), .DataOut(data8), .ChanOut(chan8), .DataValid(valid8),
    .DataReady(rdy8), .Busy(busy8), .Overrun(ovr8), .ClrOverrun(clr8));

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 30)
        $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  typedef struct { bit rdy; bit vld; int ch; int data; } vec_t;
  vec_t tab[25];

  typedef struct { int ch; int data; } word_t;
  word_t q[$];
  int    macc[CH];
  int    pc;
  bit    movr;

  function automatic int wrapv(input int v);
    logic [CW-1:0] t;
    t = CW'(v);
    return int'($signed(t));
  endfunction

  // Accumulator step from the count rules: saturate or wrap at CW bits
  function automatic int nxt(input int a, input bit d);
`ifdef ENC_SAT_EN
    if (d) return (a == (1 << (CW-1)) - 1) ? a : a + 1;
    else   return (a == -(1 << (CW-1)))    ? a : a - 1;
`else
    return wrapv(d ? a + 1 : a - 1);
`endif
  endfunction

  // Directed pulse schedule by absolute cycle number
  task automatic sched(input int c);
    pul = '0; dir = '0;
    if (c < 10) begin pul[0] = 1'b1; dir[0] = 1'b1; end
    if (c < 3)  pul[1] = 1'b1;
    if (c == 150 || c == 151 || c == 199) begin pul[2] = 1'b1; dir[2] = 1'b1; end
    if (c == 250) pul[2] = 1'b1;
    if (c >= 320 && c < 325) pul[3] = 1'b1;
    if (c == 410) begin pul[0] = 1'b1; dir[0] = 1'b1; end
  endtask

  int  r, exp8;
  bit  tick_e, busy_m;
  int  snapv[CH];

  initial begin
    tab[0]  = '{1,1,0,10};  tab[1]  = '{1,1,1,-3}; tab[2]  = '{1,1,2,0};
    tab[3]  = '{1,1,3,0};   tab[4]  = '{1,0,0,0};
    tab[5]  = '{0,1,0,0};   tab[6]  = '{0,1,0,0};  tab[7]  = '{1,1,0,0};
    tab[8]  = '{0,1,1,0};   tab[9]  = '{0,1,1,0};  tab[10] = '{0,1,1,0};
    tab[11] = '{1,1,1,0};   tab[12] = '{1,1,2,3};  tab[13] = '{1,1,3,0};
    tab[14] = '{1,0,0,0};
    tab[15] = '{1,1,0,0};   tab[16] = '{1,1,1,0};  tab[17] = '{1,1,2,-1};
    tab[18] = '{1,1,3,0};   tab[19] = '{1,0,0,0};
    tab[20] = '{1,1,0,0};   tab[21] = '{1,1,1,0};  tab[22] = '{1,1,2,0};
    tab[23] = '{1,1,3,-5};  tab[24] = '{1,0,0,0};

    rst = 1'b1; en = 1'b0; rdy = 1'b1; clr = 1'b0; pul = '0; dir = '0;
    en8 = 1'b0; rdy8 = 1'b1; clr8 = 1'b0; pul8 = '0; dir8 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_tick",  32'(tick),  0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy",  32'(busy),  0);
    chk("rst_data",  32'(dout),  0);
    chk("rst_chan",  32'(chan),  0);
    chk("rst_ovr",   32'(ovr),   0);
    @(posedge clk); #1;

    // Directed run: cycle 0 is the first cycle with Enable=1 after reset
    rst = 1'b0; en = 1'b1;
    for (int c = 0; c < 706; c++) begin
      if      (c >= 100 && c < 105) r = c - 100;
      else if (c >= 200 && c < 210) r = c - 195;
      else if (c >= 300 && c < 305) r = c - 285;
      else if (c >= 500 && c < 505) r = c - 480;
      else                          r = -1;
      rdy = (r >= 0) ? tab[r].rdy : !(c >= 305 && c < 500);
      clr = (c == 510);
      rst = (c == 602);
      sched(c);
      @(negedge clk);
      if (c < 603) chk("tick_period", 32'(tick), 32'(c % 100 == 99));
      else         chk("tick_after_reset", 32'(tick), 32'((c - 603) % 100 == 99));
      if (r >= 0) begin
        chk("tab_valid", 32'(valid), 32'(tab[r].vld));
        chk("tab_busy",  32'(busy),  32'(tab[r].vld));
        if (tab[r].vld) begin
          chk("tab_chan", 32'(chan), tab[r].ch);
          chk("tab_data", 32'($signed(dout)), tab[r].data);
        end
      end
      if (c == 450) begin
        chk("stall_valid", 32'(valid), 1);
        chk("stall_chan",  32'(chan),  0);
        chk("stall_ovr",   32'(ovr),   0);
      end
      if (c == 500 || c == 510) chk("ovr_set", 32'(ovr), 1);
      if (c == 511)             chk("ovr_clr", 32'(ovr), 0);
      if (c == 602) begin
        chk("pre_reset_idx",   32'(chan),  2);
        chk("pre_reset_valid", 32'(valid), 1);
      end
      if (c == 603) begin
        chk("post_reset_valid", 32'(valid), 0);
        chk("post_reset_busy",  32'(busy),  0);
        chk("post_reset_data",  32'(dout),  0);
        chk("post_reset_chan",  32'(chan),  0);
        chk("post_reset_ovr",   32'(ovr),   0);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; pul = '0; dir = '0;

    // 130 up-pulses into an 8-bit counter
`ifdef ENC_SAT_EN
    exp8 = 127;
`else
    exp8 = -126;
`endif
    en8 = 1'b1;
    for (int k = 0; k < 201; k++) begin
      pul8 = (k < 130) ? 4'b0001 : 4'b0000;
      dir8 = 4'b0001;
      @(negedge clk);
      if (k == 198 || k == 199) chk("tick8", 32'(tick8), 32'(k == 199));
      if (k == 200) begin
        chk("sat_valid", 32'(valid8), 1);
        chk("sat_chan",  32'(chan8),  0);
        chk("sat_data",  32'($signed(data8)), exp8);
      end
      @(posedge clk); #1;
    end
    en8 = 1'b0; pul8 = '0;

    // Random traffic against the reference model
    rst = 1'b1; clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    pc = 0; movr = 1'b0; q.delete();
    for (int i = 0; i < CH; i++) macc[i] = 0;
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(999) == 0);
      en  = ($urandom_range(99) < 97);
      rdy = (n < 2000) ? ($urandom_range(99) < 70) : ($urandom_range(99) < 10);
      clr = ($urandom_range(99) < 3);
      pul = CH'($urandom);
      dir = CH'($urandom);
      @(negedge clk);
      tick_e = !rst && en && (pc == PERIOD - 1);
      chk("rnd_tick",  32'(tick),  32'(tick_e));
      chk("rnd_valid", 32'(valid), 32'(q.size() > 0));
      chk("rnd_busy",  32'(busy),  32'(q.size() > 0));
      chk("rnd_ovr",   32'(ovr),   32'(movr));
      if (q.size() > 0) begin
        chk("rnd_chan", 32'(chan), q[0].ch);
        chk("rnd_data", 32'($signed(dout)), q[0].data);
      end
      if (rst) begin
        pc = 0; movr = 1'b0; q.delete();
        for (int i = 0; i < CH; i++) macc[i] = 0;
      end else begin
        busy_m = (q.size() > 0);
        if (busy_m && rdy) void'(q.pop_front());
        for (int i = 0; i < CH; i++) snapv[i] = pul[i] ? nxt(macc[i], dir[i]) : macc[i];
        if (tick_e && !busy_m)
          for (int i = 0; i < CH; i++) q.push_back('{i, snapv[i]});
        if (tick_e && busy_m) movr = 1'b1;
        else if (clr)         movr = 1'b0;
        for (int i = 0; i < CH; i++) macc[i] = (!en || tick_e) ? 0 : snapv[i];
        pc = (!en || tick_e) ? 0 : pc + 1;
      end
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
